// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM encodings, source indices.
package intr_ctrl_pkg;

  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd2;
  localparam logic [2:0] REG_CTL  = 3'd4;
  localparam logic [2:0] REG_EOI  = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  localparam logic [3:0] INTNUM_NONE = 4'hF;

  localparam int unsigned SRC_TIMER = 0;
  localparam int unsigned SRC_KEYS  = 1;
  localparam int unsigned SRC_SW    = 2;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module prio_enc #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] REQ,
  output logic [3:0]   IDX,
  output logic         VALID
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    IDX   = 4'd0;
    VALID = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        IDX   = 4'(i);
        VALID = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, mask/global enable,
// fixed-priority arbitration and a request/acknowledge/end-of-interrupt sequencer.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned      ABITS = 16,
  parameter int unsigned      DBITS = 16,
  parameter int unsigned      NSRC  = 3,
  parameter logic [ABITS-1:0] RBASE = ABITS'(16'hFFD0)
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic [ABITS-1:0] ABUS,
  output logic [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  input  logic [NSRC-1:0]  INTR,
  output logic             IRQ,
  output logic [3:0]       INTNUM,
  input  logic             IACK
);

  logic [NSRC-1:0]  pend_q, pend_d, mask_q, mask_d, prev_q;
  logic             gie_q, gie_d;
  logic [1:0]       state_q, state_d;
  logic             irq_q, irq_d;
  logic [3:0]       intnum_q, intnum_d;

  logic [ABITS-1:0] off;
  logic [2:0]       reg_sel;
  logic             hit, wr_pend, wr_mask, wr_ctl, wr_eoi;
  logic [NSRC-1:0]  edges, w1c, elig, elig_nxt, cur_oh, ack_clr;
  logic [3:0]       win_idx;
  logic             win_vld;
  logic [DBITS-1:0] rdata;
  logic             unused_wbus;

  // Bus decode: four word registers at even offsets from RBASE.
  assign off     = ABUS - RBASE;
  assign hit     = (off < ABITS'(8)) && !off[0];
  assign reg_sel = off[2:0];
  assign wr_pend = WE && hit && (reg_sel == REG_PEND);
  assign wr_mask = WE && hit && (reg_sel == REG_MASK);
  assign wr_ctl  = WE && hit && (reg_sel == REG_CTL);
  assign wr_eoi  = WE && hit && (reg_sel == REG_EOI);
  assign unused_wbus = ^WBUS[DBITS-1:NSRC];

  assign edges  = INTR & ~prev_q;
  assign w1c    = wr_pend ? WBUS[NSRC-1:0] : '0;
  assign elig   = pend_q & mask_q & {NSRC{gie_q}};
  assign cur_oh = NSRC'(1) << (intnum_q - 4'd1);

  prio_enc #(.N(NSRC)) u_prio (
    .REQ   (elig),
    .IDX   (win_idx),
    .VALID (win_vld)
  );

  // Register updates; a new edge always beats a clear in the same cycle.
  always_comb begin
    mask_d   = wr_mask ? WBUS[NSRC-1:0] : mask_q;
    gie_d    = wr_ctl ? WBUS[0] : gie_q;
    elig_nxt = ((pend_q & ~w1c) | edges) & mask_d & {NSRC{gie_d}};
    pend_d   = (pend_q & ~w1c & ~ack_clr) | edges;
  end

  // Sequencer; withdraw looks at next-cycle eligibility so IACK can win a same-cycle clear.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    intnum_d = intnum_q;
    ack_clr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d  = ST_REQ;
          irq_d    = 1'b1;
          intnum_d = win_idx + 4'd1;
        end
      end
      ST_REQ: begin
        if (IACK) begin
          state_d = ST_SERV;
          irq_d   = 1'b0;
          ack_clr = cur_oh;
        end else if ((elig_nxt & cur_oh) == '0) begin
          state_d  = ST_IDLE;
          irq_d    = 1'b0;
          intnum_d = INTNUM_NONE;
        end
      end
      ST_SERV: begin
        if (wr_eoi) begin
          state_d  = ST_IDLE;
          intnum_d = INTNUM_NONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        irq_d    = 1'b0;
        intnum_d = INTNUM_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      pend_q   <= '0;
      mask_q   <= '0;
      gie_q    <= 1'b0;
      prev_q   <= '0;
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      intnum_q <= INTNUM_NONE;
    end else begin
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      gie_q    <= gie_d;
      prev_q   <= INTR;
      state_q  <= state_d;
      irq_q    <= irq_d;
      intnum_q <= intnum_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_PEND: rdata = DBITS'(pend_q);
      REG_MASK: rdata = DBITS'(mask_q);
      REG_CTL:  rdata = DBITS'({state_q == ST_SERV, gie_q});
      REG_EOI:  rdata = DBITS'(intnum_q);
      default:  rdata = '0;
    endcase
  end

  assign RBUS   = (RE && hit) ? rdata : 'z;
  assign IRQ    = irq_q;
  assign INTNUM = intnum_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios then random traffic, checked
// every cycle against a behavioural model of the controller's rules.
module tb_intr_ctrl;

  localparam logic [15:0] RBASE = 16'hFFD0;

  logic        clk = 1'b0, init = 1'b1, re = 1'b0, we = 1'b0, iack = 1'b0;
  logic [15:0] abus = 16'h0, wbus = 16'h0;
  logic [2:0]  intr = 3'b0;
  wire  [15:0] rbus;
  logic        irq;
  logic [3:0]  intnum;

  intr_ctrl #(.ABITS(16), .DBITS(16), .NSRC(3), .RBASE(RBASE)) dut (
    .CLK(clk), .INIT(init), .ABUS(abus), .RBUS(rbus), .RE(re), .WBUS(wbus),
    .WE(we), .INTR(intr), .IRQ(irq), .INTNUM(intnum), .IACK(iack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          irq;
    int          num;
    bit          rd;
    logic [15:0] rd_val;
    bit          c_en;
    bit          c_irq;
    int          c_num;
    bit          cr_en;
    logic [15:0] cr_val;
    bit          cz_en;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, cyc_n = 0;

  // directed constant expectations for the current cycle
  bit          c_en = 0, c_irq = 0, cr_en = 0, cz_en = 0;
  int          c_num = 0;
  logic [15:0] cr_val = 0;

  // behavioural model state: m_num is the current interrupt number, 0 when none
  bit [2:0] m_pend, m_mask, m_prev;
  bit       m_gie, m_req, m_serv, m_known = 0;
  int       m_num;

  function automatic void model_step(bit hit, int off);
    bit [2:0] edges, w1c, pend_n, mask_n, elig_now, elig_n;
    bit gie_n, w;
    if (init) begin
      m_pend = 0; m_mask = 0; m_gie = 0; m_req = 0; m_serv = 0; m_num = 0;
      m_prev = 0; m_known = 1;
      return;
    end
    if (!m_known) return;
    w        = we && hit;
    edges    = intr & ~m_prev;
    elig_now = m_pend & m_mask & {3{m_gie}};
    w1c      = (w && off == 0) ? wbus[2:0] : 3'b0;
    mask_n   = (w && off == 2) ? wbus[2:0] : m_mask;
    gie_n    = (w && off == 4) ? wbus[0] : m_gie;
    pend_n   = (m_pend & ~w1c) | edges;
    elig_n   = pend_n & mask_n & {3{gie_n}};
    if (m_serv) begin
      if (w && off == 6) begin m_serv = 0; m_num = 0; end
    end else if (m_req) begin
      if (iack) begin
        m_req = 0; m_serv = 1;
        pend_n[m_num-1] = edges[m_num-1];
      end else if (!elig_n[m_num-1]) begin
        m_req = 0; m_num = 0;
      end
    end else if (elig_now != 0) begin
      for (int i = 2; i >= 0; i--) if (elig_now[i]) m_num = i + 1;
      m_req = 1;
    end
    m_pend = pend_n; m_mask = mask_n; m_gie = gie_n; m_prev = intr;
  endfunction

  // Push this cycle's expectation, advance the model, move to the next cycle.
  task automatic tick();
    exp_t e;
    int off;
    bit hit;
    off = int'(abus) - int'(RBASE);
    hit = (off == 0) || (off == 2) || (off == 4) || (off == 6);
    if (m_known) begin
      e.cyc = cyc_n; e.irq = m_req; e.num = (m_num == 0) ? 15 : m_num;
      e.rd = re && hit;
      case (off)
        0:       e.rd_val = 16'(m_pend);
        2:       e.rd_val = 16'(m_mask);
        4:       e.rd_val = 16'({m_serv, m_gie});
        6:       e.rd_val = 16'(e.num);
        default: e.rd_val = 16'h0;
      endcase
      e.c_en = c_en; e.c_irq = c_irq; e.c_num = c_num;
      e.cr_en = cr_en; e.cr_val = cr_val; e.cz_en = cz_en;
      sb.push_back(e);
    end
    model_step(hit, off);
    cyc_n++;
    @(negedge clk);
    re = 0; we = 0; iack = 0; c_en = 0; cr_en = 0; cz_en = 0;
  endtask

  task automatic wr(int off, logic [15:0] d);
    we = 1; abus = RBASE + 16'(off); wbus = d;
  endtask

  task automatic rd(int off, logic [15:0] c);
    re = 1; abus = RBASE + 16'(off); cr_en = 1; cr_val = c;
  endtask

  task automatic ex(bit i, int n);
    c_en = 1; c_irq = i; c_num = n;
  endtask

  task automatic chk(string nm, int cyc, logic [15:0] act, logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  function automatic bit undriven(logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic chk_z(string nm, int cyc, logic [15:0] act);
    total++;
    if (!undriven(act)) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=released", nm, cyc, act);
    end
  endtask

  // Monitor: pops one expectation per cycle, between input update and the next posedge.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("irq", e.cyc, 16'(irq), 16'(e.irq));
        chk("intnum", e.cyc, 16'(intnum), 16'(e.num));
        if (e.rd) chk("rbus", e.cyc, rbus, e.rd_val);
        else      chk_z("rbus_idle", e.cyc, rbus);
        if (e.c_en) begin
          chk("c_irq", e.cyc, 16'(irq), 16'(e.c_irq));
          chk("c_intnum", e.cyc, 16'(intnum), 16'(e.c_num));
        end
        if (e.cr_en) chk("c_rbus", e.cyc, rbus, e.cr_val);
        if (e.cz_en) chk_z("c_rbus_z", e.cyc, rbus);
      end
    end
  end

  initial begin : drv
    int k;
    @(negedge clk);
    init = 1; tick(); tick();                       // 0-1
    init = 0; wr(2, 16'h0007); tick();              // 2
    wr(4, 16'h0001); tick();                        // 3
    repeat (6) tick();                              // 4-9
    intr = 3'b010; tick();                          // 10
    intr = 3'b000; rd(0, 16'h0002); tick();         // 11
    ex(1, 2); iack = 1; tick();                     // 12
    ex(0, 2); rd(4, 16'h0003); tick();              // 13
    wr(6, 16'h1234); tick();                        // 14
    ex(0, 15); rd(4, 16'h0001); tick();             // 15
    intr = 3'b100; tick();                          // 16
    tick();                                         // 17
    intr = 3'b101; ex(1, 3); tick();                // 18
    ex(1, 3); tick();                               // 19
    ex(1, 3); iack = 1; tick();                     // 20
    intr = 3'b000; ex(0, 3); rd(0, 16'h0001); tick(); // 21
    ex(0, 3); wr(6, 16'h0000); tick();              // 22
    ex(0, 15); tick();                              // 23
    ex(1, 1); wr(0, 16'h0001); tick();              // 24
    ex(0, 15); intr = 3'b001; tick();               // 25
    intr = 3'b000; tick();                          // 26
    ex(1, 1); wr(0, 16'h0001); iack = 1; tick();    // 27
    ex(0, 1); rd(4, 16'h0003); tick();              // 28
    wr(6, 16'h0000); tick();                        // 29
    ex(0, 15); rd(0, 16'h0000); tick();             // 30
    wr(4, 16'h0000); tick();                        // 31
    intr = 3'b010; tick();                          // 32
    intr = 3'b000; tick();                          // 33
    intr = 3'b010; wr(0, 16'h0002); tick();         // 34
    intr = 3'b000; rd(0, 16'h0002); tick();         // 35
    intr = 3'b001; tick();                          // 36
    intr = 3'b000; ex(0, 15); rd(0, 16'h0003); tick(); // 37
    wr(2, 16'h0000); tick();                        // 38
    ex(0, 15); wr(4, 16'h0001); tick();             // 39
    ex(0, 15); tick();                              // 40
    wr(2, 16'hFFFF); tick();                        // 41
    rd(2, 16'h0007); tick();                        // 42
    ex(1, 1); re = 1; abus = RBASE + 16'd8; cz_en = 1; tick(); // 43
    ex(1, 1); abus = RBASE + 16'd2; cz_en = 1; iack = 1; tick(); // 44
    init = 1; ex(0, 1); tick();                     // 45
    init = 0; ex(0, 15); rd(4, 16'h0000); iack = 1; tick(); // 46
    ex(0, 15); rd(0, 16'h0000); tick();             // 47

    repeat (3000) begin
      init = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) intr = 3'($urandom_range(0, 7));
      k    = $urandom_range(0, 10);
      abus = (k == 10) ? RBASE - 16'd2 : RBASE + 16'(k);
      re   = 1'($urandom_range(0, 1));
      we   = ($urandom_range(0, 4) == 0);
      wbus = 16'($urandom);
      iack = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
      tick();
    end

    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain cyc=%0d got=%0d want=0", cyc_n, sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
